// File: rtl/seg_scan_decoder.sv
// Scan-bus snooper for a 4-digit multiplexed 7-segment display: debounces each digit dwell
// and decodes the segment pattern. Define SEG_HEX_EN to also decode the hex letters A-F.
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic        code_err,
    output logic        frame_done
);

    typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

    typedef struct packed {
        logic       ok;
        logic       blank;
        logic [3:0] val;
    } dec_t;

    localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

    logic [3:0] an_s_reg, an_p_reg;
    logic [6:0] seg_s_reg, seg_p_reg;
    state_t     state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic [3:0] mask_reg, mask_next;
    logic       code_err_reg, code_err_next;
    logic       frame_done_reg, frame_done_next;
    logic       accept;
    logic       an_ok;
    logic       same;
    logic [3:0] sel;
    logic [3:0] mask_or;
    dec_t       dec;

    function automatic dec_t decode_seg(input logic [6:0] s);
        dec_t d;
        d.ok    = 1'b1;
        d.blank = 1'b0;
        d.val   = 4'h0;
        case (s)
            7'b0000001: d.val = 4'h0;
            7'b1001111: d.val = 4'h1;
            7'b0010010: d.val = 4'h2;
            7'b0000110: d.val = 4'h3;
            7'b1001100: d.val = 4'h4;
            7'b0100100: d.val = 4'h5;
            7'b0100000: d.val = 4'h6;
            7'b0001111: d.val = 4'h7;
            7'b0000000: d.val = 4'h8;
            7'b0001100: d.val = 4'h9;
`ifdef SEG_HEX_EN
            7'b0001000: d.val = 4'hA;
            7'b1100000: d.val = 4'hB;
            7'b0110001: d.val = 4'hC;
            7'b1000010: d.val = 4'hD;
            7'b0110000: d.val = 4'hE;
            7'b0111000: d.val = 4'hF;
`endif
            7'b1111111: begin
                d.ok    = 1'b0;
                d.blank = 1'b1;
                d.val   = 4'hF;
            end
            default: d.ok = 1'b0;
        endcase
        return d;
    endfunction

    // Sample stage plus one-deep history used for the stability comparison.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_s_reg  <= 4'hF;
            seg_s_reg <= 7'h7F;
            an_p_reg  <= 4'hF;
            seg_p_reg <= 7'h7F;
        end else begin
            an_s_reg  <= an;
            seg_s_reg <= seg;
            an_p_reg  <= an_s_reg;
            seg_p_reg <= seg_s_reg;
        end
    end

    always_comb begin
        an_ok = 1'b0;
        case (an_s_reg)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: an_ok = 1'b1;
            default:                            an_ok = 1'b0;
        endcase
    end

    assign same = ({an_s_reg, seg_s_reg} == {an_p_reg, seg_p_reg});
    assign sel  = ~an_s_reg;
    assign dec  = decode_seg(seg_s_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        if (!an_ok) begin
            state_next = IDLE;
            cnt_next   = 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = TRACK;
                    cnt_next   = 8'd1;
                end
                HELD: begin
                    if (!same) begin
                        state_next = TRACK;
                        cnt_next   = 8'd1;
                    end
                end
                TRACK: begin
                    if (!same) begin
                        cnt_next = 8'd1;
                    end else begin
                        cnt_next = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;
                        // Leaving TRACK on acceptance guarantees a single accept per dwell.
                        if (cnt_next == STABLE_LIM) begin
                            accept     = 1'b1;
                            state_next = HELD;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = 8'd0;
                end
            endcase
        end
    end

    // Frame tracking: the completing acceptance sets its bit and the mask wraps to empty.
    always_comb begin
        mask_or         = mask_reg | (accept ? sel : 4'b0000);
        frame_done_next = (mask_or == 4'b1111);
        mask_next       = frame_done_next ? 4'b0000 : mask_or;
        code_err_next   = accept && !dec.ok && !dec.blank;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_reg       <= 4'b0000;
            code_err_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            mask_reg       <= mask_next;
            code_err_reg   <= code_err_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign code_err   = code_err_reg;
    assign frame_done = frame_done_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] digit_reg;
            logic       valid_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    digit_reg <= 4'hF;
                    valid_reg <= 1'b0;
                end else if (accept && sel[gi]) begin
                    if (dec.ok) begin
                        digit_reg <= dec.val;
                        valid_reg <= 1'b1;
                    end else begin
                        // Undecodable patterns keep the old nibble; blank forces F.
                        if (dec.blank) digit_reg <= 4'hF;
                        valid_reg <= 1'b0;
                    end
                end
            end

            assign digits[gi*4 +: 4] = digit_reg;
            assign digit_valid[gi]   = valid_reg;
        end
    endgenerate

endmodule
